iterative_shift_left_logic: RTL and testbench

ITERATIVE_SHIFT_LEFT_LOGIC -- requirements
Module: iterative_shift_left_logic

---
 rtl/iterative_shift_left_logic_pkg.sv | 11 +
 rtl/mux2.sv | 9 +
 rtl/shift_left_stage.sv | 38 +++
 rtl/iterative_shift_left_logic.sv | 107 ++++++++++
 tb/tb_iterative_shift_left_logic.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/iterative_shift_left_logic_pkg.sv
// Shared constants for the iterative left shifter: data width, stage count, FSM encoding.
package iterative_shift_left_logic_pkg;
    localparam int WIDTH  = 32;
    localparam int STAGES = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_t;
endpackage

// File: rtl/mux2.sv
// Single-bit 2:1 mux cell; selects d1_i when sel_i is high.
module mux2 (
    input  logic sel_i,
    input  logic d0_i,
    input  logic d1_i,
    output logic y_o
);
    assign y_o = sel_i ? d1_i : d0_i;
endmodule

// File: rtl/shift_left_stage.sv
// One power-of-two left-shift step built from mux2 cells; shifts by 2^amt_i when en_i,
// otherwise passes data_i through. Purely combinational.
module shift_left_stage #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 5,
    parameter int SEL_W  = 3
) (
    input  logic [WIDTH-1:0] data_i,
    input  logic [SEL_W-1:0] amt_i,
    input  logic             en_i,
    output logic [WIDTH-1:0] data_o
);
    logic [STAGES-1:0][WIDTH-1:0] shifted;
    logic [STAGES:0][WIDTH-1:0]   chain;
    logic [STAGES-1:0]            sel;

    assign chain[0] = data_i;

    // Each chain link swaps in the 2^k-shifted wiring only when stage k is selected.
    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        assign sel[k] = en_i && (amt_i == SEL_W'(k));
        for (genvar j = 0; j < WIDTH; j++) begin : g_bit
            if (j >= 2**k) begin : g_src
                assign shifted[k][j] = data_i[j - 2**k];
            end else begin : g_zero
                assign shifted[k][j] = 1'b0;
            end
            mux2 u_mux (
                .sel_i (sel[k]),
                .d0_i  (chain[k][j]),
                .d1_i  (shifted[k][j]),
                .y_o   (chain[k+1][j])
            );
        end
    end

    assign data_o = chain[STAGES];
endmodule

// File: rtl/iterative_shift_left_logic.sv
// Iterative 32-bit logical left shifter: one power-of-two stage per cycle, done pulses
// five edges after the accepting edge; start is ignored while busy.
module iterative_shift_left_logic #(
    parameter int WIDTH  = iterative_shift_left_logic_pkg::WIDTH,
    parameter int STAGES = iterative_shift_left_logic_pkg::STAGES
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] out,
    output logic             overflow
);
    import iterative_shift_left_logic_pkg::*;

    localparam int                CNT_W = $clog2(STAGES);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(STAGES - 1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]   out_q, out_d;
    logic [STAGES-1:0]  amt_q, amt_d;
    logic               ovf_flag_q, ovf_flag_d;
    logic               ovf_q, ovf_d;
    logic               done_q, done_d;
    logic               stage_en;
    logic [WIDTH-1:0]   stage_out;

    assign stage_en = (state_q == SHIFT) && amt_q[cnt_q];

    shift_left_stage #(
        .WIDTH  (WIDTH),
        .STAGES (STAGES),
        .SEL_W  (CNT_W)
    ) u_stage (
        .data_i (acc_q),
        .amt_i  (cnt_q),
        .en_i   (stage_en),
        .data_o (stage_out)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        amt_d      = amt_q;
        ovf_flag_d = ovf_flag_q;
        out_d      = out_q;
        ovf_d      = ovf_q;
        done_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = SHIFT;
                    cnt_d      = '0;
                    acc_d      = a;
                    amt_d      = b[STAGES-1:0];
                    ovf_flag_d = |b[WIDTH-1:STAGES];
                end
            end
            SHIFT: begin
                acc_d = stage_out;
                cnt_d = cnt_q + 1'b1;
                // Result and overflow publish together on the final stage edge.
                if (cnt_q == LAST) begin
                    state_d = DONE;
                    out_d   = ovf_flag_q ? '0 : stage_out;
                    ovf_d   = ovf_flag_q;
                    done_d  = 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            acc_q      <= '0;
            amt_q      <= '0;
            ovf_flag_q <= 1'b0;
            out_q      <= '0;
            ovf_q      <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            amt_q      <= amt_d;
            ovf_flag_q <= ovf_flag_d;
            out_q      <= out_d;
            ovf_q      <= ovf_d;
            done_q     <= done_d;
        end
    end

    assign busy     = (state_q != IDLE);
    assign done     = done_q;
    assign out      = out_q;
    assign overflow = ovf_q;
endmodule

// File: tb/tb_iterative_shift_left_logic.sv
// Directed-vector bench for the iterative left shifter.
module tb_iterative_shift_left_logic;
    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] out_w;
    logic        overflow;

    int total = 0;
    int bad   = 0;

    iterative_shift_left_logic #(.WIDTH(32), .STAGES(5)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .out      (out_w),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issues one operation, scrambles inputs after acceptance, returns latency (-1 on timeout).
    task automatic run_op(input logic [31:0] av, input logic [31:0] bv,
                          output int lat, output logic [31:0] got, output logic got_ovf);
        start = 1'b1; a = av; b = bv;
        tick();
        start = 1'b0; a = ~av; b = 32'h5;
        lat = -1;
        for (int i = 1; i <= 20; i++) begin
            tick();
            a = a + 32'h1111_1111;
            if (done === 1'b1) begin
                lat = i;
                break;
            end
        end
        got = out_w;
        got_ovf = overflow;
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; a = 32'hFFFF_FFFF; b = 32'h0;
        tick(); tick();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", done); end
        total++; if (out_w !== 32'h0) begin bad++; $display("FAIL reset_out: got %h want 0", out_w); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL reset_ovf: got %b want 0", overflow); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        int lat; logic [31:0] got; logic go;
        run_op(32'h0000_0001, 32'd31, lat, got, go);
        total++; if (lat != 5) begin bad++; $display("FAIL basic_latency: got %0d want 5", lat); end
        total++; if (got !== 32'h8000_0000) begin bad++; $display("FAIL basic_out: got %h want 80000000", got); end
        total++; if (go !== 1'b0) begin bad++; $display("FAIL basic_ovf: got %b want 0", go); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL basic_done_width: got %b want 0", done); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL basic_idle_after: got %b want 0", busy); end
    endtask

    task automatic test_patterns();
        logic [31:0] av [4] = '{32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'h1234_5678, 32'h0000_0003};
        logic [31:0] bv [4] = '{32'd4,         32'd0,         32'd8,         32'd31};
        logic [31:0] ev [4] = '{32'hEADB_EEF0, 32'hDEAD_BEEF, 32'h3456_7800, 32'h8000_0000};
        int lat; logic [31:0] got; logic go;
        for (int i = 0; i < 4; i++) begin
            run_op(av[i], bv[i], lat, got, go);
            total++;
            if (got !== ev[i] || go !== 1'b0 || lat != 5)
                begin bad++; $display("FAIL pattern_%0d: got %h ovf %b lat %0d want %h ovf 0 lat 5", i, got, go, lat, ev[i]); end
        end
    endtask

    task automatic test_overflow();
        int lat; logic [31:0] got; logic go;
        run_op(32'hFFFF_FFFF, 32'd32, lat, got, go);
        total++; if (got !== 32'h0 || go !== 1'b1) begin bad++; $display("FAIL ovf_b32: got %h/%b want 0/1", got, go); end
        run_op(32'hFFFF_FFFF, 32'h8000_0000, lat, got, go);
        total++; if (got !== 32'h0 || go !== 1'b1) begin bad++; $display("FAIL ovf_bmsb: got %h/%b want 0/1", got, go); end
        run_op(32'h0000_0001, 32'd5, lat, got, go);
        total++; if (got !== 32'h20 || go !== 1'b0) begin bad++; $display("FAIL ovf_clear: got %h/%b want 20/0", got, go); end
    endtask

    task automatic test_hold();
        int lat; logic [31:0] got; logic go;
        int changes = 0;
        run_op(32'hDEAD_BEEF, 32'd4, lat, got, go);
        for (int i = 0; i < 6; i++) begin
            a = 32'h0101_0101 * i; b = i;
            tick();
            if (out_w !== 32'hEADB_EEF0 || overflow !== 1'b0 || done !== 1'b0) changes++;
        end
        total++; if (changes != 0) begin bad++; $display("FAIL hold_stable: got %0d changes want 0", changes); end
    endtask

    task automatic test_busy_ignore();
        int dones = 0; int lat = -1; logic [31:0] got = 32'hX;
        start = 1'b1; a = 32'h1; b = 32'd1;
        tick();
        for (int i = 1; i <= 14; i++) begin
            a = 32'h0001_0101 * i; b = i;
            tick();
            if (done === 1'b1) begin
                dones++;
                if (dones == 1) begin lat = i; got = out_w; end
                start = 1'b0;
            end
        end
        start = 1'b0;
        total++; if (dones != 1) begin bad++; $display("FAIL ignore_dones: got %0d want 1", dones); end
        total++; if (got !== 32'h2) begin bad++; $display("FAIL ignore_out: got %h want 2", got); end
        total++; if (lat != 5) begin bad++; $display("FAIL ignore_latency: got %0d want 5", lat); end
    endtask

    task automatic test_reset_mid();
        int lat; logic [31:0] got; logic go;
        int dones = 0;
        run_op(32'hF, 32'd3, lat, got, go);
        total++; if (got !== 32'h78) begin bad++; $display("FAIL rmid_pre: got %h want 78", got); end
        start = 1'b1; a = 32'hFF; b = 32'd1;
        tick();
        start = 1'b0;
        tick(); tick();
        reset = 1'b1;
        tick();
        total++;
        if (busy !== 1'b0 || done !== 1'b0 || out_w !== 32'h0 || overflow !== 1'b0)
            begin bad++; $display("FAIL rmid_clear: got busy %b done %b out %h ovf %b want all 0", busy, done, out_w, overflow); end
        start = 1'b1;
        tick();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rmid_reset_priority: got busy %b want 0", busy); end
        reset = 1'b0; start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (done === 1'b1) dones++;
        end
        total++; if (dones != 0) begin bad++; $display("FAIL rmid_no_done: got %0d want 0", dones); end
        run_op(32'hF, 32'd3, lat, got, go);
        total++; if (got !== 32'h78 || lat != 5) begin bad++; $display("FAIL rmid_restart: got %h lat %0d want 78 lat 5", got, lat); end
    endtask

    task automatic test_back_to_back();
        int acc_cyc [4];
        logic [31:0] outs [4];
        int nacc = 0; int nout = 0;
        logic prev_busy;
        start = 1'b1; a = 32'h1; b = 32'd1;
        prev_busy = busy;
        for (int cyc = 1; cyc <= 16; cyc++) begin
            tick();
            if (!prev_busy && busy && nacc < 4) begin
                acc_cyc[nacc] = cyc; nacc++;
                b = (b == 32'd1) ? 32'd2 : 32'd1;
            end
            if (done === 1'b1 && nout < 4) begin outs[nout] = out_w; nout++; end
            prev_busy = busy;
        end
        start = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        total++;
        if (nacc < 2 || nout < 2) begin
            bad++; $display("FAIL b2b_count: got %0d accepts %0d results want 2+ each", nacc, nout);
        end else begin
            total++; if (acc_cyc[1] - acc_cyc[0] != 7) begin bad++; $display("FAIL b2b_spacing: got %0d want 7", acc_cyc[1] - acc_cyc[0]); end
            total++; if (outs[0] !== 32'h2) begin bad++; $display("FAIL b2b_first: got %h want 2", outs[0]); end
            total++; if (outs[1] !== 32'h4) begin bad++; $display("FAIL b2b_second: got %h want 4", outs[1]); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_patterns();
        test_overflow();
        test_hold();
        test_busy_ignore();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end
endmodule
